// File: rtl/bus_target_8088.sv
// 8088 minimum-mode bus responder: demultiplexes AD/A on ALE, decodes one window and turns hit
// RD_n/WR_n strobes into req/ack back-end transactions. Optional watchdog: BUS_TARGET_TIMEOUT_EN.
module bus_target_8088 #(
   parameter logic [19:0] BASE_ADDR   = 20'h00000,
   parameter logic [19:0] ADDR_MASK   = 20'hF0000,
   parameter bit          IO_SPACE    = 1'b0,
   parameter int unsigned WAIT_STATES = 1
`ifdef BUS_TARGET_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   inout  wire  [7:0]  ad,
   input  logic [11:0] a,
   input  logic        ale,
   input  logic        iom,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        den_n,
   output logic        ready,
   output logic        req_valid,
   output logic [19:0] req_adr,
   output logic        req_io,
   output logic        req_we,
   output logic [7:0]  req_wdat,
   input  logic        req_ack,
   input  logic [7:0]  rsp_rdat,
`ifdef BUS_TARGET_TIMEOUT_EN
   output logic        timeout,
`endif
   output logic        hit
);

   typedef enum logic [2:0] {IDLE, ADDR, REQ, RD_DRIVE, WR_END} state_e;

   state_e      state_q, state_d;
   logic [19:0] adr_q, adr_d;
   logic        io_q, io_d;
   logic        hit_q, hit_d;
   logic        we_q, we_d;
   logic [7:0]  wdat_q, wdat_d;
   logic [7:0]  rdat_q, rdat_d;
   logic        req_valid_q, req_valid_d;
   logic        ack_seen_q, ack_seen_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [19:0] bus_adr;
   logic        decode_hit;
   logic        latch_en;
   logic        strobe_ok;
   logic        ack_now;
   logic        wait_done;
   logic        to_fire;
   logic        handshake_done;
   logic        drive_ad;

   assign bus_adr    = {a, ad};
   assign decode_hit = ((bus_adr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) && (iom == IO_SPACE);
   assign latch_en   = ale && ((state_q == IDLE) || (state_q == ADDR));
   assign strobe_ok  = !ale && hit_q && (rd_n ^ wr_n);
   assign ack_now    = (state_q == REQ) && req_valid_q && req_ack;
   // The counter decrements on the same edge we test it, so "one left" means the wait is over.
   assign wait_done  = (cnt_q <= 4'd1);

`ifdef BUS_TARGET_TIMEOUT_EN
   logic [7:0] wdog_q, wdog_d;
   assign to_fire = (state_q == REQ) && req_valid_q && (wdog_q == 8'(TIMEOUT_CYCLES - 1));
`else
   assign to_fire = 1'b0;
`endif

   assign handshake_done = ack_seen_q || ack_now || to_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (ale) state_d = ADDR;
         end
         ADDR: begin
            if (ale)             state_d = ADDR;
            else if (!hit_q)     state_d = IDLE;
            else if (strobe_ok)  state_d = REQ;
         end
         REQ: begin
            if (handshake_done && wait_done) state_d = we_q ? WR_END : RD_DRIVE;
         end
         RD_DRIVE: begin
            if (rd_n) state_d = IDLE;
         end
         WR_END: begin
            if (wr_n) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      adr_d       = adr_q;
      io_d        = io_q;
      hit_d       = hit_q;
      we_d        = we_q;
      wdat_d      = wdat_q;
      rdat_d      = rdat_q;
      req_valid_d = req_valid_q;
      ack_seen_d  = ack_seen_q;
      cnt_d       = cnt_q;
      if (latch_en) begin
         adr_d = bus_adr;
         io_d  = iom;
         hit_d = decode_hit;
      end
      if ((state_q == ADDR) && strobe_ok) begin
         req_valid_d = 1'b1;
         ack_seen_d  = 1'b0;
         we_d        = !wr_n;
         cnt_d       = 4'(WAIT_STATES);
         if (!wr_n) wdat_d = ad;
      end
      if (state_q == REQ) begin
         cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
         // A late ack on the timeout edge still wins the read data.
         if (to_fire) begin
            req_valid_d = 1'b0;
            ack_seen_d  = 1'b1;
            if (!we_q) rdat_d = 8'hFF;
         end
         if (ack_now) begin
            req_valid_d = 1'b0;
            ack_seen_d  = 1'b1;
            if (!we_q) rdat_d = rsp_rdat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adr_q       <= 20'h00000;
         io_q        <= 1'b0;
         hit_q       <= 1'b0;
         we_q        <= 1'b0;
         wdat_q      <= 8'h00;
         rdat_q      <= 8'h00;
         req_valid_q <= 1'b0;
         ack_seen_q  <= 1'b0;
         cnt_q       <= 4'd0;
      end else begin
         adr_q       <= adr_d;
         io_q        <= io_d;
         hit_q       <= hit_d;
         we_q        <= we_d;
         wdat_q      <= wdat_d;
         rdat_q      <= rdat_d;
         req_valid_q <= req_valid_d;
         ack_seen_q  <= ack_seen_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef BUS_TARGET_TIMEOUT_EN
   always_comb begin
      wdog_d = wdog_q;
      if ((state_q == ADDR) && strobe_ok) wdog_d = 8'd0;
      else if (state_q == REQ)            wdog_d = wdog_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= 8'd0;
      end else begin
         wdog_q <= wdog_d;
      end
   end

   assign timeout = to_fire;
`endif

   always_comb begin
      ready     = (state_q != REQ);
      drive_ad  = (state_q == RD_DRIVE) && !rd_n && !den_n;
      req_valid = req_valid_q;
      req_adr   = adr_q;
      req_io    = io_q;
      req_we    = we_q;
      req_wdat  = wdat_q;
      hit       = hit_q;
   end

   assign ad = drive_ad ? rdat_q : 8'bz;

endmodule

// File: tb/tb_bus_target_8088.sv
// Directed bench for bus_target_8088: a memory-space and an I/O-space target share one 8088 bus.
// Define BUS_TARGET_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_bus_target_8088;

   logic        clk = 1'b0;
   logic        rst_n;
   wire  [7:0]  ad;
   logic [7:0]  ad_drv;
   logic        ad_oe;
   logic [11:0] a;
   logic        ale, iom, rd_n, wr_n, den_n;

   logic        mem_ready, mem_valid, mem_io, mem_we, mem_ack, mem_hit;
   logic [19:0] mem_adr;
   logic [7:0]  mem_wdat, mem_rsp;
   logic        io_ready, io_valid, io_io, io_we, io_ack, io_hit;
   logic [19:0] io_adr;
   logic [7:0]  io_wdat, io_rsp;
`ifdef BUS_TARGET_TIMEOUT_EN
   logic        mem_timeout, io_timeout;
`endif

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   // Bus pull-up: a released AD reads 8'hFF.
   pullup (ad);
   assign ad = ad_oe ? ad_drv : 8'bz;

   bus_target_8088 #(
      .IO_SPACE(1'b0)
`ifdef BUS_TARGET_TIMEOUT_EN
      , .TIMEOUT_CYCLES(8)
`endif
   ) u_mem (
      .clk(clk), .rst_n(rst_n), .ad(ad), .a(a), .ale(ale), .iom(iom),
      .rd_n(rd_n), .wr_n(wr_n), .den_n(den_n), .ready(mem_ready),
      .req_valid(mem_valid), .req_adr(mem_adr), .req_io(mem_io), .req_we(mem_we),
      .req_wdat(mem_wdat), .req_ack(mem_ack), .rsp_rdat(mem_rsp),
`ifdef BUS_TARGET_TIMEOUT_EN
      .timeout(mem_timeout),
`endif
      .hit(mem_hit)
   );

   bus_target_8088 #(
      .IO_SPACE(1'b1)
`ifdef BUS_TARGET_TIMEOUT_EN
      , .TIMEOUT_CYCLES(8)
`endif
   ) u_io (
      .clk(clk), .rst_n(rst_n), .ad(ad), .a(a), .ale(ale), .iom(iom),
      .rd_n(rd_n), .wr_n(wr_n), .den_n(den_n), .ready(io_ready),
      .req_valid(io_valid), .req_adr(io_adr), .req_io(io_io), .req_we(io_we),
      .req_wdat(io_wdat), .req_ack(io_ack), .rsp_rdat(io_rsp),
`ifdef BUS_TARGET_TIMEOUT_EN
      .timeout(io_timeout),
`endif
      .hit(io_hit)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // T1 address phase: ALE high for one clock with the address on A/AD, then AD released.
   task automatic applyStimulus(input logic [19:0] addr, input logic iom_v);
      ale    = 1'b1;
      a      = addr[19:8];
      ad_drv = addr[7:0];
      ad_oe  = 1'b1;
      iom    = iom_v;
      tick();
      ale    = 1'b0;
      ad_oe  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ale = 1'b0; a = '0; ad_drv = '0; ad_oe = 1'b0; iom = 1'b0;
      rd_n = 1'b1; wr_n = 1'b1; den_n = 1'b1;
      mem_ack = 1'b0; mem_rsp = '0; io_ack = 1'b0; io_rsp = '0;
      #12;
      checkOutput("rst_mem_ready", mem_ready, 1);
      checkOutput("rst_mem_valid", mem_valid, 0);
      checkOutput("rst_mem_hit", mem_hit, 0);
      checkOutput("rst_mem_adr", mem_adr, 0);
      checkOutput("rst_io_ready", io_ready, 1);
      checkOutput("rst_ad", ad, 8'hFF);
      #10 rst_n = 1'b1;
      tick();
      tick();

      // Memory read 0x01234, ack 3 cycles after req_valid rises.
      applyStimulus(20'h01234, 1'b0);
      rd_n = 1'b0; den_n = 1'b0;
      #1;
      checkOutput("rd_hit", mem_hit, 1);
      checkOutput("rd_io_hit", io_hit, 0);
      checkOutput("rd_adr", mem_adr, 20'h01234);
      checkOutput("rd_ready_t2", mem_ready, 1);
      tick();
      checkOutput("rd_ready_c1", mem_ready, 0);
      checkOutput("rd_valid_c1", mem_valid, 1);
      checkOutput("rd_we", mem_we, 0);
      tick();
      checkOutput("rd_ready_c2", mem_ready, 0);
      tick();
      checkOutput("rd_ready_c3", mem_ready, 0);
      tick();
      checkOutput("rd_ready_c4", mem_ready, 0);
      mem_ack = 1'b1; mem_rsp = 8'hA5;
      tick();
      mem_ack = 1'b0; mem_rsp = 8'h00;
      #1;
      checkOutput("rd_ready_c5", mem_ready, 1);
      checkOutput("rd_valid_drop", mem_valid, 0);
      checkOutput("rd_data", ad, 8'hA5);
      rd_n = 1'b1; den_n = 1'b1;
      #1;
      checkOutput("rd_release", ad, 8'hFF);
      tick();

      // I/O write 0x00060 <- 0x3C, immediate ack.
      applyStimulus(20'h00060, 1'b1);
      wr_n = 1'b0; ad_drv = 8'h3C; ad_oe = 1'b1;
      #1;
      checkOutput("wr_io_hit", io_hit, 1);
      checkOutput("wr_mem_hit", mem_hit, 0);
      tick();
      checkOutput("wr_ready_c1", io_ready, 0);
      checkOutput("wr_valid", io_valid, 1);
      checkOutput("wr_we", io_we, 1);
      checkOutput("wr_wdat", io_wdat, 8'h3C);
      checkOutput("wr_adr", io_adr, 20'h00060);
      checkOutput("wr_reqio", io_io, 1);
      checkOutput("wr_mem_ready", mem_ready, 1);
      io_ack = 1'b1;
      tick();
      io_ack = 1'b0;
      checkOutput("wr_ready_c2", io_ready, 1);
      checkOutput("wr_valid_drop", io_valid, 0);
      wr_n = 1'b1; ad_oe = 1'b0;
      tick();
      checkOutput("wr_single_req", io_valid, 0);
      checkOutput("wr_ready_idle", io_ready, 1);

      // Miss at 0x12345.
      applyStimulus(20'h12345, 1'b0);
      rd_n = 1'b0; den_n = 1'b0;
      #1;
      checkOutput("miss_hit", mem_hit, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("miss_ready", mem_ready, 1);
         checkOutput("miss_valid", mem_valid, 0);
         checkOutput("miss_ad", ad, 8'hFF);
      end
      rd_n = 1'b1; den_n = 1'b1;
      tick();

      // Both strobes low: hold in ADDR, then proceed as a read once WR_n rises.
      applyStimulus(20'h01000, 1'b0);
      rd_n = 1'b0; wr_n = 1'b0; den_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("ill_valid", mem_valid, 0);
         checkOutput("ill_ready", mem_ready, 1);
      end
      wr_n = 1'b1;
      tick();
      checkOutput("ill_then_valid", mem_valid, 1);
      checkOutput("ill_then_we", mem_we, 0);
      checkOutput("ill_then_ready", mem_ready, 0);
      mem_ack = 1'b1; mem_rsp = 8'h5A;
      tick();
      mem_ack = 1'b0; mem_rsp = 8'h00;
      checkOutput("ill_rd_data", ad, 8'h5A);
      checkOutput("ill_rd_ready", mem_ready, 1);
      rd_n = 1'b1; den_n = 1'b1;
      tick();

      // Async reset while a read request is outstanding.
      applyStimulus(20'h02000, 1'b0);
      rd_n = 1'b0; den_n = 1'b0;
      tick();
      checkOutput("rstm_valid_pre", mem_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstm_valid", mem_valid, 0);
      checkOutput("rstm_ready", mem_ready, 1);
      checkOutput("rstm_ad", ad, 8'hFF);
      checkOutput("rstm_hit", mem_hit, 0);
      rd_n = 1'b1; den_n = 1'b1;
      #2 rst_n = 1'b1;
      tick();

      // Clean read after reset.
      applyStimulus(20'h0ABCD, 1'b0);
      rd_n = 1'b0; den_n = 1'b0;
      tick();
      checkOutput("post_valid", mem_valid, 1);
      mem_ack = 1'b1; mem_rsp = 8'h77;
      tick();
      mem_ack = 1'b0; mem_rsp = 8'h00;
      checkOutput("post_data", ad, 8'h77);
      checkOutput("post_adr", mem_adr, 20'h0ABCD);
      checkOutput("post_ready", mem_ready, 1);
      rd_n = 1'b1; den_n = 1'b1;
      tick();

`ifdef BUS_TARGET_TIMEOUT_EN
      // Read that is never acked: watchdog fires in REQ cycle 8.
      applyStimulus(20'h03000, 1'b0);
      rd_n = 1'b0; den_n = 1'b0;
      tick();
      for (int k = 1; k < 8; k++) begin
         checkOutput("to_quiet", mem_timeout, 0);
         checkOutput("to_ready_low", mem_ready, 0);
         tick();
      end
      checkOutput("to_pulse", mem_timeout, 1);
      checkOutput("to_pulse_ready", mem_ready, 0);
      tick();
      checkOutput("to_ready", mem_ready, 1);
      checkOutput("to_data", ad, 8'hFF);
      checkOutput("to_valid", mem_valid, 0);
      checkOutput("to_end", mem_timeout, 0);
      rd_n = 1'b1; den_n = 1'b1;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
